// File: rtl/alu_normalize.sv
// Leading-zero/leading-one counter with normalizing shift.
// Five-step binary search (16,8,4,2,1); fixed six-cycle cadence.
module alu_normalize (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [5:0]  count,
  output logic [31:0] norm
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_mode;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic [2:0]  r_step;
  logic        r_done;
  logic [5:0]  r_count;
  logic [31:0] r_norm;

  logic        w_hit;
  logic [4:0]  w_k;
  logic [31:0] w_shift;
  logic [31:0] w_work_nx;
  logic [4:0]  w_cnt_nx;
  logic        w_last;
  logic        w_all;
  logic        w_accept;

  // One search step per cycle; r_step 0..4 selects k = 16..1
  always_comb begin
    w_hit   = 1'b0;
    w_k     = 5'd0;
    w_shift = r_work;
    unique case (r_step)
      3'd0: begin
        w_k     = 5'd16;
        w_hit   = (r_work[31:16] == {16{r_mode}});
        w_shift = {r_work[15:0], 16'h0000};
      end
      3'd1: begin
        w_k     = 5'd8;
        w_hit   = (r_work[31:24] == {8{r_mode}});
        w_shift = {r_work[23:0], 8'h00};
      end
      3'd2: begin
        w_k     = 5'd4;
        w_hit   = (r_work[31:28] == {4{r_mode}});
        w_shift = {r_work[27:0], 4'h0};
      end
      3'd3: begin
        w_k     = 5'd2;
        w_hit   = (r_work[31:30] == {2{r_mode}});
        w_shift = {r_work[29:0], 2'b00};
      end
      3'd4: begin
        w_k     = 5'd1;
        w_hit   = (r_work[31] == r_mode);
        w_shift = {r_work[30:0], 1'b0};
      end
      default: begin
        w_k     = 5'd0;
        w_hit   = 1'b0;
        w_shift = r_work;
      end
    endcase
  end

  // Step sum is at most 31, so the 5-bit accumulator cannot wrap
  assign w_work_nx = w_hit ? w_shift : r_work;
  assign w_cnt_nx  = w_hit ? (r_cnt + w_k) : r_cnt;
  assign w_last    = (r_state == S_RUN) && (r_step == 3'd4);
  assign w_all     = (w_work_nx[31] == r_mode);
  assign w_accept  = (r_state == S_IDLE) && start;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nx = S_RUN;
      S_RUN:  if (r_step == 3'd4) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= 1'b0;
      r_work  <= 32'h0;
      r_cnt   <= 5'd0;
      r_step  <= 3'd0;
      r_done  <= 1'b0;
      r_count <= 6'd0;
      r_norm  <= 32'h0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mode <= mode;
        r_work <= operand;
        r_cnt  <= 5'd0;
        r_step <= 3'd0;
      end else if (r_state == S_RUN) begin
        r_work <= w_work_nx;
        r_cnt  <= w_cnt_nx;
        r_step <= r_step + 3'd1;
        if (w_last) begin
          r_done <= 1'b1;
          // Bit 31 still matching after all steps means all 32 bits matched
          if (w_all) begin
            r_count <= 6'd32;
            r_norm  <= 32'h0;
          end else begin
            r_count <= {1'b0, w_cnt_nx};
            r_norm  <= w_work_nx;
          end
        end
      end
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign count = r_count;
  assign norm  = r_norm;

endmodule

// File: doc/alu_normalize.md
ALU_NORMALIZE -- requirements
Module: alu_normalize

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-003 start  input  1  request; sampled only while busy=0.
REQ-004 mode  input  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO); sampled with start.
REQ-005 operand  input  32  value to normalize; sampled with start.
REQ-006 busy  output  1  high while an operation is in its stage cycles.
REQ-007 done  output  1  one-cycle pulse; count and norm are valid.
REQ-008 count  output  6  number of consecutive leading bits of operand equal to mode; range 0..32.
REQ-009 norm  output  32  operand shifted left by count, zero-filled; 0 when count=32.

Function
REQ-010 The block SHALL be the inverse companion of the left shifter: it finds the shift amount, rather than applying one, by a 5-step binary search.
REQ-011 Accept: at a rising edge with start=1, busy=0 and reset=0, the block SHALL latch operand and mode, clear its internal count, and set busy=1.
REQ-012 Stages: the 5 edges following accept SHALL perform, in order, steps k=16, 8, 4, 2, 1.
REQ-013 Each step: if the top k bits of the working value all equal mode, the working value SHALL shift left by k and k SHALL be added to the internal count; otherwise both SHALL be unchanged.
REQ-014 Result: after step k=1, if bit 31 of the working value still equals mode, count SHALL be 32 and norm SHALL be 0.
REQ-015 Result: otherwise, count SHALL be the accumulated sum and norm SHALL be operand << count, zero-filled, for both modes.
REQ-016 Operand zero (CLZ) and 0xFFFFFFFF (CLO) SHALL take the count=32 path.
REQ-017 Latency: busy SHALL be 1 for exactly 5 cycles after the accept edge.
REQ-018 On the 5th stage edge, the block SHALL drop busy to 0, register count and norm, and drive done=1 for exactly one cycle.
REQ-019 count and norm SHALL hold their last result until the next operation's completion edge.
REQ-020 count and norm SHALL NOT show intermediate values while busy=1.
REQ-021 start while busy=1 SHALL be ignored: no queueing, and the running operation SHALL be unaffected.
REQ-022 operand and mode changes while busy=1 SHALL have no effect.
REQ-023 start during the done cycle (busy=0) SHALL be accepted, so back-to-back operations complete every 6 cycles.
REQ-024 Fixed timing: latency SHALL be data-independent, with no early termination.
REQ-025 Width rule: the internal count SHALL never exceed 31 before the count=32 rule, and no overflow SHALL be possible in 6 bits.

Reset
REQ-026 reset=1 at a rising edge SHALL force busy=0, done=0, count=0, norm=0, and clear internal working and count state.
REQ-027 Reset SHALL take priority over start.
REQ-028 Reset asserted mid-operation SHALL abort the operation, with no done pulse afterward.
REQ-029 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-030 CLZ, operand=0x00010000 -> 6th edge after accept: done=1, count=15, norm=0x80000000; busy was high for exactly 5 cycles.
REQ-031 CLZ, 0x00000000 -> count=32, norm=0x00000000; CLZ, 0x80000000 -> count=0, norm=0x80000000.
REQ-032 CLO, 0xFFFF0F00 -> count=16, norm=0x0F000000; CLO, 0xFFFFFFFF -> count=32, norm=0; CLO, 0x7FFFFFFF -> count=0, norm=0x7FFFFFFF.
REQ-033 CLZ 0x00000001 accepted; start with 0x00F00000 pulsed on busy cycles 2 and 4 -> only one done, count=31, norm=0x80000000.
REQ-034 CLZ 0x0000FFFF accepted, then start with CLO 0xC0000000 held in the done cycle -> done pulses 6 cycles apart, giving count=16/norm=0xFFFF0000 and then count=2/norm=0x00000000.
REQ-035 Operation accepted, reset=1 on busy cycle 3 -> next edge busy=0, done=0, count=0, norm=0, and no later done.
